line_buffer_9x9: RTL and testbench

Upstream feeder for the 9x9 window buffer. It accepts a raster pixel stream, one 8-bit pixel per qualified cycle. For each accepted pixel it presents the nine vertically aligned pixels of the current column on S1_o..S9_o, from oldest row to newest, which is exactly the column input the window buffer consumes. Eight COLS-deep line delays give the vertical alignment, and row/column counters track frame position and signal frame completion.

---
 rtl/line_buffer_9x9_if.sv | 30 +++
 rtl/line_buffer_9x9.sv | 124 ++++++++++++
 tb/tb_line_buffer_9x9.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/line_buffer_9x9_if.sv
// rtl/line_buffer_9x9_if.sv - pixel-in / column-tap-out bundle for line_buffer_9x9
interface line_buffer_9x9_if;
  logic       done_i;
  logic [7:0] data_i;
  logic [7:0] S1_o;
  logic [7:0] S2_o;
  logic [7:0] S3_o;
  logic [7:0] S4_o;
  logic [7:0] S5_o;
  logic [7:0] S6_o;
  logic [7:0] S7_o;
  logic [7:0] S8_o;
  logic [7:0] S9_o;
  logic       done_o;
  logic       progress_done_o;

  // Upstream pixel source: drives the raster stream, observes the column taps.
  modport master (
    output done_i, data_i,
    input  S1_o, S2_o, S3_o, S4_o, S5_o, S6_o, S7_o, S8_o, S9_o,
    input  done_o, progress_done_o
  );

  // The line buffer itself.
  modport slave (
    input  done_i, data_i,
    output S1_o, S2_o, S3_o, S4_o, S5_o, S6_o, S7_o, S8_o, S9_o,
    output done_o, progress_done_o
  );
endinterface

// File: rtl/line_buffer_9x9.sv
// rtl/line_buffer_9x9.sv - eight chained line delays producing 9-tall pixel columns (option: LINE_BUFFER_9X9_PRIME_EN)
module line_buffer_9x9 #(
  parameter int COLS = 11,
  parameter int ROWS = 11
) (
  input logic               clk,
  input logic               rst,
  line_buffer_9x9_if.slave  bus
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  // mem[0] is L1 (oldest row), mem[7] is L8 (previous row). All lines share
  // the column pointer, so the entry at col_cnt is exactly the pixel written
  // COLS accepts ago, i.e. the line tail; overwriting it in place is the shift.
  logic [7:0]    mem [8][COLS];
  logic [7:0]    tap_q [9];
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          done_q;
  logic          prog_q;
  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          frame_last;
  logic          taps_real;

  assign accept     = bus.done_i;
  assign col_last   = (col_cnt == CW'(COLS - 1));
  assign row_last   = (row_cnt == RW'(ROWS - 1));
  assign frame_last = col_last && row_last;

`ifdef LINE_BUFFER_9X9_PRIME_EN
  logic primed;

  // Once row 8 of a frame is reached all nine taps carry this frame's data;
  // dropping the flag on the last pixel forces every frame to re-prime.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      primed <= 1'b0;
    end else if (accept) begin
      if (frame_last) begin
        primed <= 1'b0;
      end else if (row_cnt >= RW'(8)) begin
        primed <= 1'b1;
      end
    end
  end

  assign taps_real = primed || (row_cnt >= RW'(8));
`else
  assign taps_real = 1'b1;
`endif

  // Line storage: each line hands its tail to the line below, new pixel enters L8.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 8; k++) begin
        for (int c = 0; c < COLS; c++) begin
          mem[k][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int k = 0; k < 7; k++) begin
        mem[k][col_cnt] <= mem[k+1][col_cnt];
      end
      mem[7][col_cnt] <= bus.data_i;
    end
  end

  // Column taps: line tails plus the live pixel, held while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 9; k++) begin
        tap_q[k] <= '0;
      end
    end else if (accept) begin
      for (int k = 0; k < 8; k++) begin
        tap_q[k] <= mem[k][col_cnt];
      end
      tap_q[8] <= bus.data_i;
    end
  end

  // Raster position: column wraps every row, both wrap at the last frame pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_cnt <= '0;
        row_cnt <= row_last ? '0 : row_cnt + RW'(1);
      end else begin
        col_cnt <= col_cnt + CW'(1);
      end
    end
  end

  // Registered qualifiers: one pulse per accepted pixel, frame pulse on its last pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
      prog_q <= 1'b0;
    end else begin
      done_q <= accept && taps_real;
      prog_q <= accept && frame_last;
    end
  end

  assign bus.S1_o            = tap_q[0];
  assign bus.S2_o            = tap_q[1];
  assign bus.S3_o            = tap_q[2];
  assign bus.S4_o            = tap_q[3];
  assign bus.S5_o            = tap_q[4];
  assign bus.S6_o            = tap_q[5];
  assign bus.S7_o            = tap_q[6];
  assign bus.S8_o            = tap_q[7];
  assign bus.S9_o            = tap_q[8];
  assign bus.done_o          = done_q;
  assign bus.progress_done_o = prog_q;

endmodule

// File: tb/tb_line_buffer_9x9.sv
// tb/tb_line_buffer_9x9.sv - scoreboard bench for line_buffer_9x9
module tb_line_buffer_9x9;

  localparam int COLS = 11;
  localparam int ROWS = 11;
  localparam int FRAME = COLS * ROWS;

  typedef struct {
    logic [71:0] taps;
    logic        done;
    logic        prog;
  } exp_t;

  logic clk;
  logic rst;
  line_buffer_9x9_if bus ();

  line_buffer_9x9 #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  hist [$];
  exp_t        sb [$];
  logic [71:0] last_taps;

  function automatic logic [71:0] obs_taps();
    return {bus.S1_o, bus.S2_o, bus.S3_o, bus.S4_o, bus.S5_o,
            bus.S6_o, bus.S7_o, bus.S8_o, bus.S9_o};
  endfunction

  // Accept the next raster pixel, predict its column from the pixel history,
  // then compare what the DUT shows one edge later.
  task automatic accept_px();
    exp_t       e;
    exp_t       got;
    int         g;
    int         idx;
    int         fpos;
    logic [7:0] v;
    logic [7:0] t;
    g = hist.size();
    v = 8'((g + 1) % 256);
    hist.push_back(v);
    e.taps = '0;
    for (int k = 1; k <= 9; k++) begin
      idx = g - (9 - k) * COLS;
      t = (idx >= 0) ? hist[idx] : 8'd0;
      e.taps[(9 - k) * 8 +: 8] = t;
    end
    fpos = g % FRAME;
`ifdef LINE_BUFFER_9X9_PRIME_EN
    e.done = ((fpos / COLS) >= 8);
`else
    e.done = 1'b1;
`endif
    e.prog = (fpos == FRAME - 1);
    sb.push_back(e);
    @(negedge clk);
    bus.done_i = 1'b1;
    bus.data_i = v;
    @(posedge clk);
    #1;
    bus.done_i = 1'b0;
    got = sb.pop_front();
    checks++;
    if (obs_taps() !== got.taps) begin
      errors++;
      $display("FAIL taps px=%0d got=%h exp=%h", g, obs_taps(), got.taps);
    end
    checks++;
    if (bus.done_o !== got.done) begin
      errors++;
      $display("FAIL done_o px=%0d got=%b exp=%b", g, bus.done_o, got.done);
    end
    checks++;
    if (bus.progress_done_o !== got.prog) begin
      errors++;
      $display("FAIL progress_done_o px=%0d got=%b exp=%b", g, bus.progress_done_o, got.prog);
    end
    last_taps = got.taps;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.done_i = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (obs_taps() !== last_taps || bus.done_o !== 1'b0 || bus.progress_done_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold got=%h/%b/%b exp=%h/0/0", obs_taps(), bus.done_o,
               bus.progress_done_o, last_taps);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (obs_taps() !== 72'd0 || bus.done_o !== 1'b0 || bus.progress_done_o !== 1'b0) begin
      errors++;
      $display("FAIL %s got=%h/%b/%b exp=0/0/0", name, obs_taps(), bus.done_o, bus.progress_done_o);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.done_i = 1'b0;
    bus.data_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    hist.delete();
    sb.delete();
    last_taps = '0;
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge clk);
    #1;
    check_zero("reset_state");
    accept_px();
`ifndef LINE_BUFFER_9X9_PRIME_EN
    checks++;
    if (bus.done_o !== 1'b1 || bus.S9_o !== 8'd1 || obs_taps() !== 72'd1) begin
      errors++;
      $display("FAIL first_pixel got=%b/%h exp=1/000000000000000001", bus.done_o, obs_taps());
    end
`endif
  endtask

  task automatic test_alignment();
    do_reset();
    for (int i = 0; i <= 88; i++) accept_px();
    checks++;
    if (bus.S9_o !== 8'd89 || bus.S8_o !== 8'd78 || bus.S7_o !== 8'd67 || bus.S1_o !== 8'd1) begin
      errors++;
      $display("FAIL alignment got S9=%0d S8=%0d S7=%0d S1=%0d exp 89/78/67/1",
               bus.S9_o, bus.S8_o, bus.S7_o, bus.S1_o);
    end
    checks++;
    if (bus.done_o !== 1'b1) begin
      errors++;
      $display("FAIL done_at_88 got=%b exp=1", bus.done_o);
    end
  endtask

  task automatic test_stall_and_reset_mid();
    do_reset();
    for (int i = 0; i <= 50; i++) accept_px();
    repeat (3) idle_cycle();
    checks++;
    if (bus.S9_o !== 8'd51) begin
      errors++;
      $display("FAIL stall_s9 got=%0d exp=51", bus.S9_o);
    end
    accept_px();
    checks++;
    if (bus.S9_o !== 8'd52 || bus.S8_o !== 8'd41) begin
      errors++;
      $display("FAIL after_stall got S9=%0d S8=%0d exp 52/41", bus.S9_o, bus.S8_o);
    end
    for (int i = 52; i <= 60; i++) accept_px();
    #2;
    rst = 1'b0;
    #1;
    check_zero("reset_mid_frame");
    @(negedge clk);
    rst = 1'b1;
    hist.delete();
    sb.delete();
    last_taps = '0;
    accept_px();
    for (int i = 1; i <= 12; i++) accept_px();
  endtask

  task automatic test_back_to_back_frames();
    do_reset();
    for (int i = 0; i <= 120; i++) accept_px();
    checks++;
    if (bus.progress_done_o !== 1'b1 || bus.done_o !== 1'b1) begin
      errors++;
      $display("FAIL frame_end got prog=%b done=%b exp 1/1", bus.progress_done_o, bus.done_o);
    end
    accept_px();
    checks++;
    if (bus.S9_o !== 8'd122 || bus.S8_o !== 8'd111 || bus.progress_done_o !== 1'b0) begin
      errors++;
      $display("FAIL next_frame got S9=%0d S8=%0d prog=%b exp 122/111/0",
               bus.S9_o, bus.S8_o, bus.progress_done_o);
    end
    for (int i = 122; i <= 241; i++) begin
      if (i % 37 == 0) idle_cycle();
      accept_px();
    end
    checks++;
    if (bus.progress_done_o !== 1'b1) begin
      errors++;
      $display("FAIL frame2_end got=%b exp=1", bus.progress_done_o);
    end
    idle_cycle();
  endtask

  initial begin
    rst = 1'b0;
    bus.done_i = 1'b0;
    bus.data_i = '0;
    last_taps = '0;
    test_reset();
    test_alignment();
    test_stall_and_reset_mid();
    test_back_to_back_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
